// File: rtl/matrix_generate_3x3_8bit.sv
// matrix_generate_3x3_8bit: RGB->luma, two line buffers, 3x3 window; define MATRIX_GRAY_ROUND_EN for rounded luma
module matrix_generate_3x3_8bit #(
  parameter int IMG_WIDTH = 640
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] dataR,
  input  logic [7:0] dataG,
  input  logic [7:0] dataB,
  output logic [7:0] dout0,
  output logic [7:0] dout1,
  output logic [7:0] dout2,
  output logic [7:0] dout3,
  output logic [7:0] dout4,
  output logic [7:0] dout5,
  output logic [7:0] dout6,
  output logic [7:0] dout7,
  output logic [7:0] dout8
);
  localparam int PW = $clog2(IMG_WIDTH);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(IMG_WIDTH);
`ifdef MATRIX_GRAY_ROUND_EN
  localparam logic [15:0] RND = 16'd128;
`else
  localparam logic [15:0] RND = 16'd0;
`endif
  logic [7:0] gray_q, gray_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [7:0] l1_mem [IMG_WIDTH];
  logic [7:0] l2_mem [IMG_WIDTH];
  logic [7:0] l1_tap, l2_tap;
  logic [7:0] win_q [9];
  logic [7:0] win_d [9];
  // Both buffers advance in lockstep, so one pointer and one fill counter serve both.
  always_comb begin
    gray_d = 8'((16'd77 * dataR + 16'd150 * dataG + 16'd29 * dataB + RND) >> 8);
    ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    fill_d = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    l1_tap = (fill_q == FULL) ? l1_mem[ptr_q] : 8'd0;
    l2_tap = (fill_q == FULL) ? l2_mem[ptr_q] : 8'd0;
    win_d[0] = win_q[1];
    win_d[1] = win_q[2];
    win_d[2] = l2_tap;
    win_d[3] = win_q[4];
    win_d[4] = win_q[5];
    win_d[5] = l1_tap;
    win_d[6] = win_q[7];
    win_d[7] = win_q[8];
    win_d[8] = gray_q;
  end
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      gray_q <= '0;
      ptr_q  <= '0;
      fill_q <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      gray_q <= gray_d;
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end
  // Storage is left unreset; the fill gate hides stale contents until overwritten.
  always_ff @(posedge clk) begin
    l1_mem[ptr_q] <= gray_q;
    l2_mem[ptr_q] <= l1_tap;
  end
  assign dout0 = win_q[0];
  assign dout1 = win_q[1];
  assign dout2 = win_q[2];
  assign dout3 = win_q[3];
  assign dout4 = win_q[4];
  assign dout5 = win_q[5];
  assign dout6 = win_q[6];
  assign dout7 = win_q[7];
  assign dout8 = win_q[8];
endmodule

// File: tb/tb_matrix_generate_3x3_8bit.sv
// tb_matrix_generate_3x3_8bit: directed checks of luma, line buffers and 3x3 window with IMG_WIDTH=4
module tb_matrix_generate_3x3_8bit;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [7:0] dataR = '0, dataG = '0, dataB = '0;
  logic [7:0] dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7, dout8;
  logic [7:0] d [9];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  matrix_generate_3x3_8bit #(.IMG_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .dataR(dataR), .dataG(dataG), .dataB(dataB),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3), .dout4(dout4),
    .dout5(dout5), .dout6(dout6), .dout7(dout7), .dout8(dout8)
  );
  assign d[0] = dout0;
  assign d[1] = dout1;
  assign d[2] = dout2;
  assign d[3] = dout3;
  assign d[4] = dout4;
  assign d[5] = dout5;
  assign d[6] = dout6;
  assign d[7] = dout7;
  assign d[8] = dout8;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pix(input int base, input int k);
    return (k < 0) ? 8'd0 : 8'((base + k) % 256);
  endfunction
  task automatic rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    dataR = r;
    dataG = g;
    dataB = b;
  endtask
  task automatic gray_test(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic [7:0] exp);
    @(negedge clk);
    rgb(r, g, b);
    @(negedge clk);
    @(negedge clk);
    chk(tag, dout8, exp);
  endtask
  // Releases reset at the first negedge; pixel i = (base+i)%256 on all three channels.
  task automatic run_window(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rstn = 1'b0;
      for (int j = 0; j < 9; j++)
        chk($sformatf("win_b%0d_i%0d_d%0d", base, i, j), d[j], pix(base, i - (2 + (2 - j % 3) + (2 - j / 3) * W)));
      rgb(pix(base, i), pix(base, i), pix(base, i));
    end
  endtask
  initial begin
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rgb(8'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int j = 0; j < 9; j++) chk($sformatf("reset_d%0d", j), d[j], 8'd0);
    @(negedge clk);
    rstn = 1'b0;
    gray_test("gray_0", 8'd0, 8'd0, 8'd0, 8'd0);
    gray_test("gray_1", 8'd1, 8'd1, 8'd1, 8'd1);
    gray_test("gray_128", 8'd128, 8'd128, 8'd128, 8'd128);
    gray_test("gray_255", 8'd255, 8'd255, 8'd255, 8'd255);
`ifdef MATRIX_GRAY_ROUND_EN
    gray_test("w_red", 8'd255, 8'd0, 8'd0, 8'd77);
    gray_test("w_green", 8'd0, 8'd255, 8'd0, 8'd149);
    gray_test("w_blue", 8'd0, 8'd0, 8'd255, 8'd29);
    gray_test("round_r2", 8'd2, 8'd0, 8'd0, 8'd1);
`else
    gray_test("w_red", 8'd255, 8'd0, 8'd0, 8'd76);
    gray_test("w_green", 8'd0, 8'd255, 8'd0, 8'd149);
    gray_test("w_blue", 8'd0, 8'd0, 8'd255, 8'd28);
    gray_test("round_r2", 8'd2, 8'd0, 8'd0, 8'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_window(0, 300);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int j = 0; j < 9; j++) chk($sformatf("midreset_d%0d", j), d[j], 8'd0);
    @(negedge clk);
    run_window(100, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
